// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// One bit period per ckena pulse; the line (txd) is registered and idles high.
module uart_tx #(
  parameter int StopBits = 1,
  parameter int Parity   = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ckena,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       txd,
  output logic       busy,
  output logic [2:0] dbg_state_o
);

  if (StopBits < 1 || StopBits > 2) begin : g_bad_stop_bits
    $error("uart_tx: StopBits must be 1 or 2");
  end
  if (Parity < 0 || Parity > 2) begin : g_bad_parity
    $error("uart_tx: Parity must be 0 (none), 1 (odd) or 2 (even)");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    PAR   = 3'd4,
    STOP  = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        stop_q, stop_d;
  logic        par_q, par_d;
  logic        txd_q, txd_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= 8'h00;
      cnt_q   <= 3'd0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end

  // Parity is fixed at acceptance because the shift register consumes the byte.
  // cnt_q is the index of the data bit currently on the line.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    par_d   = par_q;
    txd_d   = txd_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          shift_d = data;
          cnt_d   = 3'd0;
          par_d   = (Parity == 1) ? ~(^data) : (^data);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ckena) begin
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (ckena) begin
          txd_d   = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          cnt_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (ckena) begin
          if (cnt_q == 3'd7) begin
            stop_d = 1'b0;
            if (Parity != 0) begin
              txd_d   = par_q;
              state_d = PAR;
            end else begin
              txd_d   = 1'b1;
              state_d = STOP;
            end
          end else begin
            txd_d   = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
            cnt_d   = cnt_q + 3'd1;
          end
        end
      end
      PAR: begin
        if (ckena) begin
          txd_d   = 1'b1;
          stop_d  = 1'b0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (ckena) begin
          if (stop_q == 1'(StopBits - 1)) begin
            state_d = IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready       = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign txd         = txd_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameterisations share clock, reset, ckena and data.
// Expected frames are hand-built bit vectors, bit k = k-th bit on the line.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       ckena;
  logic [7:0] data;
  logic [3:0] valid;
  logic [3:0] txd_w, ready_w, busy_w;
  logic [2:0] st_w [4];

  int  n_chk = 0;
  int  n_pass = 0;
  int  phase = 0;
  bit  tick_on = 1'b1;

  always #5 clk = ~clk;

  uart_tx #(.StopBits(1), .Parity(0)) u0 (.clock(clk), .reset(reset), .ckena(ckena), .data(data),
    .valid(valid[0]), .ready(ready_w[0]), .txd(txd_w[0]), .busy(busy_w[0]), .dbg_state_o(st_w[0]));
  uart_tx #(.StopBits(1), .Parity(1)) u1 (.clock(clk), .reset(reset), .ckena(ckena), .data(data),
    .valid(valid[1]), .ready(ready_w[1]), .txd(txd_w[1]), .busy(busy_w[1]), .dbg_state_o(st_w[1]));
  uart_tx #(.StopBits(1), .Parity(2)) u2 (.clock(clk), .reset(reset), .ckena(ckena), .data(data),
    .valid(valid[2]), .ready(ready_w[2]), .txd(txd_w[2]), .busy(busy_w[2]), .dbg_state_o(st_w[2]));
  uart_tx #(.StopBits(2), .Parity(2)) u3 (.clock(clk), .reset(reset), .ckena(ckena), .data(data),
    .valid(valid[3]), .ready(ready_w[3]), .txd(txd_w[3]), .busy(busy_w[3]), .dbg_state_o(st_w[3]));

  typedef struct {
    int          sel;
    logic [7:0]  d;
    int          nbits;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // One clock; ckena for the next edge is set here, a pulse every 4 clocks.
  task automatic step();
    @(posedge clk);
    #1;
    if (tick_on) begin
      phase = (phase + 1) % 4;
      ckena = (phase == 0);
    end else begin
      ckena = 1'b0;
    end
  endtask

  task automatic accept(input int sel, input logic [7:0] d, input bit coincide);
    int n;
    n = 0;
    while (ready_w[sel] !== 1'b1 && n < 50) begin step(); n++; end
    if (n >= 50) chk("ready_timeout", 0, 1);
    if (coincide) begin
      n = 0;
      while (ckena !== 1'b1 && n < 8) begin step(); n++; end
    end
    valid[sel] = 1'b1;
    data = d;
    step();
    chk("accepted_busy", busy_w[sel], 1);
    chk("accepted_ready", ready_w[sel], 0);
  endtask

  task automatic check_frame(input int sel, input logic [11:0] exp, input int nbits,
                             input int abort_at, input int freeze_at, input bit hold);
    int  bitpos;
    int  in_bit;
    bit  done;
    bit  frozen;
    bit  tick;
    logic exb;
    bitpos = -1;
    in_bit = 0;
    done   = 1'b0;
    frozen = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      tick = ckena;
      valid[sel] = hold ? 1'b1 : 1'($urandom_range(0, 1));
      data = 8'($urandom);
      step();
      if (tick) begin bitpos++; in_bit = 0; end
      else in_bit++;
      if (bitpos == nbits) begin
        chk("end_ready", ready_w[sel], 1);
        chk("end_busy", busy_w[sel], 0);
        chk("end_txd", txd_w[sel], 1);
        done = 1'b1;
      end else begin
        if (bitpos < 0) exb = 1'b1;
        else exb = exp[bitpos];
        chk($sformatf("txd_bit%0d", bitpos), txd_w[sel], exb);
        chk("mid_busy", busy_w[sel], 1);
        chk("mid_ready", ready_w[sel], 0);
        if (bitpos == abort_at && in_bit == 2) done = 1'b1;
        if (bitpos == freeze_at && !frozen && in_bit == 1) begin
          frozen  = 1'b1;
          tick_on = 1'b0;
          ckena   = 1'b0;
          for (int k = 0; k < 100; k++) begin
            valid[sel] = 1'($urandom_range(0, 1));
            step();
            chk("frozen_txd", txd_w[sel], exb);
            chk("frozen_busy", busy_w[sel], 1);
          end
          tick_on = 1'b1;
        end
      end
    end
    valid[sel] = hold;
    if (!done) chk("frame_timeout", 0, 1);
  endtask

  initial begin
    reset = 1'b1;
    ckena = 1'b0;
    valid = 4'b0;
    data  = 8'h00;

    tbl[0] = '{0, 8'hA5, 10, 12'({1'b1, 8'hA5, 1'b0})};
    tbl[1] = '{0, 8'h00, 10, 12'({1'b1, 8'h00, 1'b0})};
    tbl[2] = '{0, 8'hFF, 10, 12'({1'b1, 8'hFF, 1'b0})};
    tbl[3] = '{1, 8'hA5, 11, 12'({1'b1, 1'b1, 8'hA5, 1'b0})};
    tbl[4] = '{1, 8'h01, 11, 12'({1'b1, 1'b0, 8'h01, 1'b0})};
    tbl[5] = '{2, 8'hA5, 11, 12'({1'b1, 1'b0, 8'hA5, 1'b0})};
    tbl[6] = '{2, 8'h01, 11, 12'({1'b1, 1'b1, 8'h01, 1'b0})};
    tbl[7] = '{2, 8'h7E, 11, 12'({1'b1, 1'b0, 8'h7E, 1'b0})};

    repeat (3) step();
    for (int i = 0; i < 4; i++) begin
      chk("rst_txd", txd_w[i], 1);
      chk("rst_ready", ready_w[i], 1);
      chk("rst_busy", busy_w[i], 0);
    end
    reset = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      accept(tbl[i].sel, tbl[i].d, 1'b0);
      check_frame(tbl[i].sel, tbl[i].exp, tbl[i].nbits, -1, -1, 1'b0);
    end

    // valid lands on the same edge as a tick: frame waits for the next tick
    accept(0, 8'h5A, 1'b1);
    check_frame(0, 12'({1'b1, 8'h5A, 1'b0}), 10, -1, -1, 1'b0);

    // two stop bits, back-to-back with valid held high
    accept(3, 8'h00, 1'b0);
    check_frame(3, {2'b11, 1'b0, 8'h00, 1'b0}, 12, -1, -1, 1'b1);
    data = 8'hFF;
    step();
    chk("b2b_accept_busy", busy_w[3], 1);
    valid[3] = 1'b0;
    check_frame(3, {2'b11, 1'b0, 8'hFF, 1'b0}, 12, -1, -1, 1'b0);

    // reset in the middle of data bit 3 (frame bit index 4), valid also high
    accept(0, 8'hA5, 1'b0);
    check_frame(0, 12'({1'b1, 8'hA5, 1'b0}), 10, 4, -1, 1'b0);
    reset = 1'b1;
    valid[0] = 1'b1;
    step();
    chk("abort_txd", txd_w[0], 1);
    chk("abort_ready", ready_w[0], 1);
    chk("abort_busy", busy_w[0], 0);
    reset = 1'b0;
    valid[0] = 1'b0;
    step();
    chk("post_abort_ready", ready_w[0], 1);
    accept(0, 8'h3C, 1'b0);
    check_frame(0, 12'({1'b1, 8'h3C, 1'b0}), 10, -1, -1, 1'b0);

    // ticks stop for 100 clocks during frame bit 5
    accept(2, 8'hA5, 1'b0);
    check_frame(2, 12'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, -1, 5, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter: StopBits, 1, number of stop bits per frame (legal values 1 or 2).
REQ-002 SHALL have parameter: Parity, 0, parity mode (0 none, 1 odd, 2 even).
REQ-003 SHALL have port: clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: ckena  input  1  baud tick, one clock wide, once per bit period (driven by clkdiv ckout).
REQ-006 SHALL have port: data  input  8  byte to transmit, sampled on acceptance.
REQ-007 SHALL have port: valid  input  1  data holds a byte to send.
REQ-008 SHALL have port: ready  output  1  block can accept a byte this cycle.
REQ-009 SHALL have port: txd  output  1  serial line, idle high, driven from a register.
REQ-010 SHALL have port: busy  output  1  frame pending or in progress.

Function
REQ-011 SHALL implement states IDLE, WAIT, START, DATA, PAR, STOP.
REQ-012 SHALL assert ready only in IDLE and SHALL deassert busy only in IDLE.
REQ-013 SHALL accept a byte when valid=1 and ready=1, capture data into a shift register, and move to WAIT on the next edge.
REQ-014 SHALL ignore a ckena that coincides with the acceptance cycle; the frame is aligned to the next ckena.
REQ-015 In WAIT, on ckena=1, SHALL drive txd=0 and enter START.
REQ-016 SHALL advance exactly one bit per ckena=1 cycle and hold txd and state unchanged while ckena=0.
REQ-017 SHALL send 8 data bits LSB first in DATA, with a 3-bit counter counting 0..7 and no wrap past 7.
REQ-018 When Parity != 0, SHALL send one parity bit in PAR after bit 7. Odd: total ones across data and parity is odd. Even: that total is even.
REQ-019 When Parity == 0, SHALL skip PAR and go from bit 7 to STOP.
REQ-020 SHALL drive txd=1 for StopBits bit periods in STOP.
REQ-021 At the ckena that ends the last stop bit, SHALL enter IDLE with ready=1 on the next cycle.
REQ-022 A byte accepted in that next cycle SHALL start its start bit at the following ckena, so back-to-back frames have no extra idle bit.
REQ-023 SHALL ignore valid while ready=0. Changes on data after acceptance SHALL NOT affect the frame in progress.
REQ-024 Total frame length SHALL be 1 + 8 + (Parity!=0) + StopBits bit periods, each exactly one ckena interval.
REQ-025 A parameter value outside its legal range SHALL be rejected at elaboration.

Reset
REQ-026 With reset=1 at an edge, SHALL set state=IDLE, txd=1, ready=1, busy=0, and clear the bit counter and shift register.
REQ-027 Reset SHALL override valid and ckena in the same cycle.
REQ-028 Reset during a frame SHALL abandon the frame immediately, with txd=1 on the next cycle and no partial stop bit.

Verification
REQ-029 SHALL cover: Parity=0, StopBits=1, ckena every 4 clocks, data=0xA5 -> txd = 0,1,0,1,0,0,1,0,1,1, each held 4 clocks, then ready=1.
REQ-030 SHALL cover: Parity=2, data=0xA5 -> parity bit 0. Parity=1, data=0xA5 -> parity bit 1. Data=0x01 with Parity=2 -> parity bit 1.
REQ-031 SHALL cover: StopBits=2, two bytes 0x00 then 0xFF held valid continuously -> 12 bit periods each, second start bit at the ckena right after frame 1's second stop bit, no idle gap.
REQ-032 SHALL cover: valid and ckena in the same cycle -> txd stays 1 until the next ckena, then start bit lasts exactly one full interval.
REQ-033 SHALL cover: reset pulsed during data bit 3 -> txd=1, ready=1, busy=0 next cycle; a new byte 0x3C then transmits correctly.
REQ-034 SHALL cover: ckena held low for 100 clocks mid-frame -> txd and state frozen, and the frame resumes correctly once ticks return.
